// File: rtl/ddu_ctrl.sv
// Debug display unit: step/continuous CPU run control, inspection-address stepping,
// 8-digit multiplexed seven-segment scan. Optional button debounce via `define DDU_DEBOUNCE_EN.
module ddu_ctrl #(
  parameter int unsigned SCAN_DIV  = 17,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cont_sw,
  input  logic        step_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  input  logic        mem_sel,
  input  logic [31:0] mem_data,
  input  logic [31:0] reg_data,
  input  logic [31:0] pc,
  output logic        cont,
  output logic        run,
  output logic [31:0] ddu_addr,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [15:0] led
);

  localparam int unsigned CNT_W    = SCAN_DIV + 3;
  localparam int unsigned BTN_STEP = 0;
  localparam int unsigned BTN_INC  = 1;
  localparam int unsigned BTN_DEC  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT_REL
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync1_q, sync1_d;
  logic [2:0]        sync2_q, sync2_d;
  logic [2:0]        prev_q, prev_d;
  logic [2:0]        level;
  logic [2:0]        evt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cont_q, cont_d;
  logic              run_q, run_d;
  logic [7:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic [15:0]       led_q, led_d;
  logic [31:0]       ddu_addr_w;
  logic [31:0]       word;
  logic [2:0]        digit_idx;
  logic              unused_pc_bits;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hC0;  4'h1: p = 8'hF9;  4'h2: p = 8'hA4;  4'h3: p = 8'hB0;
      4'h4: p = 8'h99;  4'h5: p = 8'h92;  4'h6: p = 8'h82;  4'h7: p = 8'hF8;
      4'h8: p = 8'h80;  4'h9: p = 8'h90;  4'hA: p = 8'h88;  4'hB: p = 8'h83;
      4'hC: p = 8'hC6;  4'hD: p = 8'hA1;  4'hE: p = 8'h86;  default: p = 8'h8E;
    endcase
    return p;
  endfunction

  always_comb begin
    sync1_d = {dec_btn, inc_btn, step_btn};
    sync2_d = sync1_q;
  end

`ifdef DDU_DEBOUNCE_EN
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [2:0]      db_level_q, db_level_d;

  // Counting only while the synced level differs from the accepted one; any return
  // to the accepted level is a change of the synced level and restarts the count.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
        db_level_d[i] = sync2_q[i];
        db_cnt_d[i]   = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q   <= '{default: '0};
      db_level_q <= '0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
    end
  end

  assign level = db_level_q;
`else
  assign level = sync2_q;
`endif

  assign evt    = level & ~prev_q;
  assign prev_d = level;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (evt[BTN_STEP]) state_d = S_PULSE;
      S_PULSE:    state_d = S_WAIT_REL;
      S_WAIT_REL: if (!level[BTN_STEP]) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (cont_sw) state_d = S_IDLE;
  end

  always_comb begin
    addr_d = addr_q;
    if (evt[BTN_INC] && !evt[BTN_DEC]) begin
      addr_d = addr_q + ADDR_W'(1);
    end else if (evt[BTN_DEC] && !evt[BTN_INC]) begin
      addr_d = addr_q - ADDR_W'(1);
    end
    ddu_addr_w               = '0;
    ddu_addr_w[ADDR_W-1:0]   = addr_q;
  end

  always_comb begin
    cont_d    = cont_sw;
    run_d     = cont_sw || (state_d == S_PULSE);
    cnt_d     = cnt_q + CNT_W'(1);
    digit_idx = cnt_q[CNT_W-1:SCAN_DIV];
    word      = mem_sel ? mem_data : reg_data;
    an_d      = ~(8'h01 << digit_idx);
    seg_d     = hex_seg(word[{digit_idx, 2'b00} +: 4]);
    led_d     = {ddu_addr_w[7:0], pc[9:2]};
  end

  assign unused_pc_bits = ^{pc[31:10], pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      run_q   <= 1'b0;
      an_q    <= 8'hFE;
      seg_q   <= '1;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      run_q   <= run_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      led_q   <= led_d;
    end
  end

  assign cont     = cont_q;
  assign run      = run_q;
  assign ddu_addr = ddu_addr_w;
  assign an       = an_q;
  assign seg      = seg_q;
  assign led      = led_q;

endmodule

// File: tb/tb_ddu_ctrl.sv
// Self-checking bench for ddu_ctrl: run control, address stepping, display scan, reset behaviour.
module tb_ddu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cont_sw = 1'b0, step_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0, mem_sel = 1'b0;
  logic [31:0] mem_data = '0, reg_data = '0, pc = '0;
  logic        cont, run;
  logic [31:0] ddu_addr;
  logic [7:0]  an, seg;
  logic [15:0] led;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int run_pulses = 0;
  int run_cycles = 0;
  logic run_prev = 1'b0;
  int model_addr = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  ddu_ctrl #(.SCAN_DIV(2), .DB_CYCLES(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .cont_sw(cont_sw), .step_btn(step_btn), .inc_btn(inc_btn),
    .dec_btn(dec_btn), .mem_sel(mem_sel), .mem_data(mem_data), .reg_data(reg_data), .pc(pc),
    .cont(cont), .run(run), .ddu_addr(ddu_addr), .an(an), .seg(seg), .led(led)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping: every rising edge of run and every cycle it is high.
  always @(negedge clk) begin
    if (run === 1'b1) begin
      run_cycles++;
      if (run_prev !== 1'b1) run_pulses++;
    end
    run_prev = run;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_step(input int len, input int gap);
    step_btn = 1'b1;
    repeat (len) tick();
    step_btn = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic press_addr(input int i, input int d);
    inc_btn = i[0];
    dec_btn = d[0];
    repeat (12) tick();
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    repeat (12) tick();
    model_addr = (((model_addr + i - d) % 256) + 256) % 256;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    cmp_cnt++; if (cont !== 1'b0)        begin err_cnt++; $display("FAIL reset_cont: got %b want 0", cont); end
    cmp_cnt++; if (run !== 1'b0)         begin err_cnt++; $display("FAIL reset_run: got %b want 0", run); end
    cmp_cnt++; if (ddu_addr !== 32'h0)   begin err_cnt++; $display("FAIL reset_addr: got %h want 0", ddu_addr); end
    cmp_cnt++; if (an !== 8'hFE)         begin err_cnt++; $display("FAIL reset_an: got %h want FE", an); end
    cmp_cnt++; if (seg !== 8'hFF)        begin err_cnt++; $display("FAIL reset_seg: got %h want FF", seg); end
    cmp_cnt++; if (led !== 16'h0)        begin err_cnt++; $display("FAIL reset_led: got %h want 0000", led); end
    rst = 1'b0;
    model_addr = 0;
    tick();
  endtask

  task automatic test_step();
    int p0, c0, n;
    cont_sw = 1'b0;
    for (int k = 0; k < 2; k++) begin
      p0 = run_pulses; c0 = run_cycles;
      press_step(20, 20);
      cmp_cnt++; if (run_pulses - p0 !== 1) begin err_cnt++; $display("FAIL step_pulses: got %0d want 1", run_pulses - p0); end
      cmp_cnt++; if (run_cycles - c0 !== 1) begin err_cnt++; $display("FAIL step_width: got %0d want 1", run_cycles - c0); end
    end
    n = 6;
    p0 = run_pulses; c0 = run_cycles;
    for (int k = 0; k < n; k++) press_step($urandom_range(10, 25), $urandom_range(12, 25));
    cmp_cnt++; if (run_pulses - p0 !== n) begin err_cnt++; $display("FAIL step_rand_pulses: got %0d want %0d", run_pulses - p0, n); end
    cmp_cnt++; if (run_cycles - c0 !== n) begin err_cnt++; $display("FAIL step_rand_cycles: got %0d want %0d", run_cycles - c0, n); end
  endtask

  task automatic test_cont();
    int p0;
    cont_sw = 1'b1;
    tick();
    cmp_cnt++; if (cont !== 1'b1) begin err_cnt++; $display("FAIL cont_level: got %b want 1", cont); end
    for (int k = 0; k < 10; k++) begin
      step_btn = (k >= 3 && k < 6);
      cmp_cnt++; if (run !== 1'b1) begin err_cnt++; $display("FAIL cont_run cycle %0d: got %b want 1", k, run); end
      tick();
    end
    cont_sw = 1'b0;
    step_btn = 1'b0;
    tick();
    tick();
    cmp_cnt++; if (run !== 1'b0)  begin err_cnt++; $display("FAIL cont_off_run: got %b want 0", run); end
    cmp_cnt++; if (cont !== 1'b0) begin err_cnt++; $display("FAIL cont_off_cont: got %b want 0", cont); end
    p0 = run_pulses;
    repeat (20) tick();
    cmp_cnt++; if (run_pulses !== p0) begin err_cnt++; $display("FAIL cont_off_stray: got %0d pulses want 0", run_pulses - p0); end
  endtask

  task automatic test_addr();
    int op;
    logic [31:0] exp_addr;
    logic [15:0] exp_led;
    int dir_i [3] = '{0, 1, 1};
    int dir_d [3] = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      press_addr(dir_i[k], dir_d[k]);
      exp_addr = 32'(model_addr);
      cmp_cnt++; if (ddu_addr !== exp_addr) begin err_cnt++; $display("FAIL addr_dir%0d: got %h want %h", k, ddu_addr, exp_addr); end
    end
    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(0, 3);
      pc = $urandom;
      press_addr(op % 2, op / 2);
      exp_addr = 32'(model_addr);
      exp_led  = {exp_addr[7:0], pc[9:2]};
      cmp_cnt++; if (ddu_addr !== exp_addr) begin err_cnt++; $display("FAIL addr_rand%0d: got %h want %h", k, ddu_addr, exp_addr); end
      cmp_cnt++; if (led !== exp_led)       begin err_cnt++; $display("FAIL led_rand%0d: got %h want %h", k, led, exp_led); end
    end
  endtask

  task automatic test_display(input logic [31:0] w, input logic sel);
    int seen [8];
    int k;
    logic [7:0] exp_an, exp_seg;
    logic [31:0] sh;
    mem_sel = sel;
    if (sel) begin mem_data = w; reg_data = $urandom; end
    else     begin reg_data = w; mem_data = $urandom; end
    for (int j = 0; j < 8; j++) seen[j] = 0;
    tick();
    tick();
    for (int c = 0; c < 32; c++) begin
      k = -1;
      for (int j = 7; j >= 0; j--) if (an[j] === 1'b0) k = j;
      if (k < 0) begin
        cmp_cnt++; err_cnt++; $display("FAIL disp_an_none: got %h want one digit low", an);
      end else begin
        seen[k]++;
        exp_an  = ~(8'h01 << k);
        sh      = w >> (4 * k);
        exp_seg = seg_tab[sh[3:0]];
        cmp_cnt++; if (an !== exp_an)   begin err_cnt++; $display("FAIL disp_an: got %h want %h", an, exp_an); end
        cmp_cnt++; if (seg !== exp_seg) begin err_cnt++; $display("FAIL disp_seg digit %0d word %h: got %h want %h", k, w, seg, exp_seg); end
      end
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      cmp_cnt++; if (seen[j] !== 4) begin err_cnt++; $display("FAIL disp_dwell digit %0d: got %0d want 4", j, seen[j]); end
    end
  endtask

`ifdef DDU_DEBOUNCE_EN
  task automatic test_glitch();
    int p0;
    cont_sw = 1'b0;
    p0 = run_pulses;
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick();
    step_btn = 1'b1; tick();
    step_btn = 1'b0;
    repeat (20) tick();
    cmp_cnt++; if (run_pulses !== p0) begin err_cnt++; $display("FAIL glitch_pulse: got %0d want 0", run_pulses - p0); end
    p0 = run_pulses;
    press_step(10, 20);
    cmp_cnt++; if (run_pulses - p0 !== 1) begin err_cnt++; $display("FAIL glitch_clean: got %0d want 1", run_pulses - p0); end
  endtask
`endif

  task automatic test_reset_mid_step();
    int p0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    model_addr = 0;
    cont_sw = 1'b0;
    repeat (5) press_addr(1, 0);
    cmp_cnt++; if (ddu_addr !== 32'h5) begin err_cnt++; $display("FAIL midrst_pre_addr: got %h want 00000005", ddu_addr); end
    p0 = run_pulses;
    step_btn = 1'b1;
    for (int i = 0; i < 40 && run_pulses == p0; i++) tick();
    cmp_cnt++; if (run_pulses == p0) begin err_cnt++; $display("FAIL midrst_pulse_timeout: got 0 pulses want 1"); end
    tick();
    tick();
    rst = 1'b1;
    step_btn = 1'b0;
    tick();
    rst = 1'b0;
    p0 = run_pulses;
    cmp_cnt++; if (ddu_addr !== 32'h0) begin err_cnt++; $display("FAIL midrst_addr: got %h want 0", ddu_addr); end
    cmp_cnt++; if (run !== 1'b0)       begin err_cnt++; $display("FAIL midrst_run: got %b want 0", run); end
    cmp_cnt++; if (an !== 8'hFE)       begin err_cnt++; $display("FAIL midrst_an: got %h want FE", an); end
    cmp_cnt++; if (seg !== 8'hFF)      begin err_cnt++; $display("FAIL midrst_seg: got %h want FF", seg); end
    cmp_cnt++; if (led !== 16'h0)      begin err_cnt++; $display("FAIL midrst_led: got %h want 0000", led); end
    repeat (30) tick();
    cmp_cnt++; if (run_pulses !== p0)  begin err_cnt++; $display("FAIL midrst_release_pulse: got %0d want 0", run_pulses - p0); end
    cmp_cnt++; if (ddu_addr !== 32'h0) begin err_cnt++; $display("FAIL midrst_addr_hold: got %h want 0", ddu_addr); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_cont();
    test_addr();
    test_display(32'h1234ABCD, 1'b1);
    test_display(32'h0, 1'b0);
    for (int k = 0; k < 3; k++) test_display($urandom, 1'($urandom_range(0, 1)));
`ifdef DDU_DEBOUNCE_EN
    test_glitch();
`endif
    test_reset_mid_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
